// File: rtl/reconfig_frame_rx.sv
// reconfig_frame_rx: FLAG/ADDR/LEN/PAYLOAD/FLAG deframer feeding an N_CH-channel FWFT byte stream.
// Define RECONFIG_FRAME_CRC_EN to require a trailing CRC-16/CCITT-FALSE over ADDR, LEN and PAYLOAD.
module reconfig_frame_rx #(
    parameter int N_CH = 4,
    parameter int LEN_BYTES = 2,
    parameter logic [7:0] FLAG = 8'h7E,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT_CYC = 100000,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LEN_W = 8 * LEN_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_last,
    output logic             frame_done,
    output logic [2:0]       frame_err,
    output logic [7:0]       frame_addr,
    output logic [LEN_W-1:0] frame_len,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_PAYLOAD,
`ifdef RECONFIG_FRAME_CRC_EN
        S_CRC,
`endif
        S_EOF
    } state_t;
`ifdef RECONFIG_FRAME_CRC_EN
    localparam state_t S_POST = S_CRC;
    logic [15:0] crc;
    logic [7:0] crc_hi;
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction
`else
    localparam state_t S_POST = S_EOF;
`endif
    state_t state, state_n;
    logic [7:0] addr;
    logic [LEN_W-1:0] len_sh, len_n, remaining;
    logic [1:0] lcnt;
    logic [2:0] err, err_n;
    logic [31:0] idle_cnt;
    logic timeout, push, wr, pop, full, done, addr_bad;
    logic [CH_W+8:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;

    assign busy = state != S_IDLE;
    assign len_n = (len_sh << 8) | LEN_W'(in_data);
    assign addr_bad = int'(addr) >= N_CH;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign out_valid = count != '0;
    assign {out_last, out_ch, out_data} = out_valid ? mem[rd_ptr] : '0;
    assign pop = out_valid && out_ready;
    assign wr = push && (!full || pop);
    assign timeout = TIMEOUT_CYC != 0 && busy && !in_valid && idle_cnt == 32'(TIMEOUT_CYC - 1);

    // Only the first error of a frame is kept; err_n never overwrites a nonzero err.
    always_comb begin
        state_n = state;
        err_n = err;
        push = 1'b0;
        done = 1'b0;
        if (timeout) begin
            state_n = S_IDLE;
            done = 1'b1;
            if (err == 3'd0) err_n = 3'd4;
        end else if (in_valid) begin
            case (state)
                S_IDLE: state_n = (in_data == FLAG) ? S_ADDR : S_IDLE;
                S_ADDR: if (in_data != FLAG) begin
                    state_n = S_LEN;
                    if (int'(in_data) >= N_CH && err == 3'd0) err_n = 3'd1;
                end
                S_LEN: if (lcnt == 2'(LEN_BYTES - 1)) state_n = (len_n == '0) ? S_POST : S_PAYLOAD;
                S_PAYLOAD: begin
                    push = !addr_bad;
                    if (remaining == LEN_W'(1)) state_n = S_POST;
                    if (push && full && !pop && err == 3'd0) err_n = 3'd3;
                end
`ifdef RECONFIG_FRAME_CRC_EN
                S_CRC: if (lcnt == 2'd1) begin
                    state_n = S_EOF;
                    if ({crc_hi, in_data} != crc && err == 3'd0) err_n = 3'd5;
                end
`endif
                S_EOF: begin
                    state_n = S_IDLE;
                    done = 1'b1;
                    if (in_data != FLAG && err == 3'd0) err_n = 3'd2;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= '0;
            frame_done <= 1'b0;
            frame_err <= '0;
            frame_addr <= '0;
            frame_len <= '0;
            idle_cnt <= '0;
            lcnt <= '0;
            addr <= '0;
            len_sh <= '0;
            remaining <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
`ifdef RECONFIG_FRAME_CRC_EN
            crc <= 16'hFFFF;
            crc_hi <= '0;
`endif
        end else begin
            err <= done ? 3'd0 : err_n;
            frame_done <= done;
            frame_err <= done ? err_n : 3'd0;
            idle_cnt <= (in_valid || !busy) ? 32'd0 : idle_cnt + 32'd1;
            lcnt <= (state_n != state) ? 2'd0 : in_valid ? lcnt + 2'd1 : lcnt;
            if (done) begin
                frame_addr <= addr;
                frame_len <= len_sh;
            end
            if (in_valid && state == S_IDLE) begin
                addr <= '0;
                len_sh <= '0;
            end
            if (in_valid && state == S_ADDR && in_data != FLAG) addr <= in_data;
            if (in_valid && state == S_LEN) len_sh <= len_n;
            remaining <= (in_valid && state == S_LEN) ? len_n
                       : (in_valid && state == S_PAYLOAD) ? remaining - LEN_W'(1) : remaining;
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
`ifdef RECONFIG_FRAME_CRC_EN
            if (state == S_IDLE) crc <= 16'hFFFF;
            else if (in_valid && (state == S_LEN || state == S_PAYLOAD || (state == S_ADDR && in_data != FLAG)))
                crc <= crc_upd(crc, in_data);
            if (in_valid && state == S_CRC) crc_hi <= in_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {remaining == LEN_W'(1), addr[CH_W-1:0], in_data};
    end
endmodule

// File: tb/tb_reconfig_frame_rx.sv
// tb_reconfig_frame_rx: directed frames against reconfig_frame_rx (N_CH=4, LEN_BYTES=2, depth 16, timeout 50).
module tb_reconfig_frame_rx;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic out_valid, out_last, frame_done, busy;
    logic [7:0] out_data, frame_addr;
    logic [1:0] out_ch;
    logic [2:0] frame_err;
    logic [15:0] frame_len;
    int checks = 0, errors = 0, fd_cnt = 0;
    logic [10:0] q[$];

    always #5 clk = ~clk;

    reconfig_frame_rx #(.N_CH(4), .LEN_BYTES(2), .FLAG(8'h7E), .FIFO_DEPTH(16), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .frame_done(frame_done), .frame_err(frame_err),
        .frame_addr(frame_addr), .frame_len(frame_len), .busy(busy)
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back({out_last, out_ch, out_data});
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] s[$]);
        foreach (s[i]) begin
            in_valid = 1'b1;
            in_data = s[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input logic [2:0] e, input logic [7:0] a,
                              input logic [15:0] l, output int cyc);
        cyc = 0;
        while (!frame_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, frame_done, 1);
        check({tag, "_err"}, frame_err, e);
        check({tag, "_addr"}, frame_addr, a);
        check({tag, "_len"}, frame_len, l);
    endtask

    task automatic check_q(input string tag, input logic [10:0] e[$]);
        repeat (20) @(negedge clk);
        check({tag, "_cnt"}, q.size(), e.size());
        for (int i = 0; i < e.size() && i < q.size(); i++) check($sformatf("%s_b%0d", tag, i), q[i], e[i]);
        q.delete();
    endtask

    initial begin
        logic [7:0] s[$];
        logic [10:0] e[$];
        int cyc, fd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        check("rst_addr", frame_addr, 0);
        check("rst_len", frame_len, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        s = '{8'h7E, 8'h00, 8'h00, 8'h04, 8'hAA, 8'h99, 8'h55, 8'h66, 8'h7E};
        send(s);
        wait_frame("t1", 3'd0, 8'h00, 16'h0004, cyc);
        e = '{{1'b0, 2'd0, 8'hAA}, {1'b0, 2'd0, 8'h99}, {1'b0, 2'd0, 8'h55}, {1'b1, 2'd0, 8'h66}};
        check_q("t1", e);

        s = '{8'h7E, 8'h7E, 8'h01, 8'h01, 8'h92};
        e = {};
        for (int i = 0; i < 402; i++) begin
            s.push_back(8'(i));
            e.push_back({i == 401, 2'd1, 8'(i)});
        end
        s.push_back(8'h7E);
        send(s);
        wait_frame("t2", 3'd0, 8'h01, 16'h0192, cyc);
        check_q("t2", e);

        s = '{8'h7E, 8'h05, 8'h00, 8'h02, 8'h11, 8'h22, 8'h7E};
        send(s);
        wait_frame("t3", 3'd1, 8'h05, 16'h0002, cyc);
        e = {};
        check_q("t3", e);

        s = '{8'h7E, 8'h02, 8'h00, 8'h01, 8'h33, 8'h00};
        send(s);
        wait_frame("t4a", 3'd2, 8'h02, 16'h0001, cyc);
        s = '{8'h7E, 8'h02, 8'h00, 8'h01, 8'h44, 8'h7E};
        send(s);
        wait_frame("t4b", 3'd0, 8'h02, 16'h0001, cyc);
        e = '{{1'b1, 2'd2, 8'h33}, {1'b1, 2'd2, 8'h44}};
        check_q("t4", e);

        s = '{8'h7E, 8'h01, 8'h00, 8'h00, 8'h7E};
        send(s);
        wait_frame("zlen", 3'd0, 8'h01, 16'h0000, cyc);
        e = {};
        check_q("zlen", e);

        out_ready = 1'b0;
        s = '{8'h7E, 8'h03, 8'h00, 8'h14};
        e = {};
        for (int i = 0; i < 20; i++) begin
            s.push_back(8'(8'h10 + i));
            if (i < 16) e.push_back({1'b0, 2'd3, 8'(8'h10 + i)});
        end
        s.push_back(8'h7E);
        send(s);
        wait_frame("t5", 3'd3, 8'h03, 16'h0014, cyc);
        check("t5_held", out_valid, 1);
        out_ready = 1'b1;
        check_q("t5", e);

        out_ready = 1'b0;
        s = '{8'h7E, 8'h00, 8'h00, 8'h12};
        e = {};
        for (int i = 0; i < 16; i++) s.push_back(8'(8'h40 + i));
        send(s);
        out_ready = 1'b1;
        s = '{8'h50, 8'h51, 8'h7E};
        send(s);
        wait_frame("fullpop", 3'd0, 8'h00, 16'h0012, cyc);
        for (int i = 0; i < 18; i++) e.push_back({i == 17, 2'd0, 8'(8'h40 + i)});
        check_q("fullpop", e);

        out_ready = 1'b0;
        s = '{8'h7E, 8'h00, 8'h00, 8'h03, 8'h11};
        send(s);
        fd0 = fd_cnt;
        rst = 1'b1;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("mrst_nodone", fd_cnt, fd0);
        q.delete();

        s = '{8'h7E, 8'h00, 8'h00};
        send(s);
        wait_frame("t6", 3'd4, 8'h00, 16'h0000, cyc);
        check("t6_cycles", cyc, 51);
        check("t6_busy", busy, 0);
        @(negedge clk);
        check("t6_pulse", frame_done, 0);
        e = {};
        check_q("t6", e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
